// File: rtl/pipe_ctrl_regs_if.sv
// Control-side pipeline register bundle.
// master: pipeline controller (drives stage strobes and ID decode, reads stage state/feedback/counters)
// slave : pipe_ctrl_regs (consumes strobes and decode, returns stage valids, hazard feedback, counters)
interface pipe_ctrl_regs_if #(
   parameter int unsigned CNT_W = 32
);
   // per-stage clear / load strobes
   logic if_rst, id_rst, exe_rst, mem_rst, wb_rst;
   logic if_en, id_en, exe_en, mem_en, wb_en;

   // ID-stage decode outputs
   logic [31:0] inst_id;
   logic        is_branch_id;
   logic        mem_ren_id;
   logic        mem_wen_id;
   logic        wb_wen_id;
   logic        wb_data_src_id;
   logic [1:0]  wb_addr_src_id;

   // stage valid flags
   logic if_valid, id_valid, exe_valid, mem_valid, wb_valid;

   // hazard feedback and downstream controls
   logic [4:0] regw_addr_exe, regw_addr_mem, regw_addr_wb;
   logic       wb_wen_exe, wb_wen_mem, wb_wen_wb;
   logic       wb_data_src_exe, wb_data_src_mem, wb_data_src_wb;
   logic       is_branch_exe, is_branch_mem;
   logic       mem_ren_mem, mem_wen_mem;

   // performance counters
   logic [CNT_W-1:0] retired_cnt, bubble_cnt, flush_cnt;

   modport master (
      output if_rst, id_rst, exe_rst, mem_rst, wb_rst,
      output if_en, id_en, exe_en, mem_en, wb_en,
      output inst_id, is_branch_id, mem_ren_id, mem_wen_id, wb_wen_id, wb_data_src_id, wb_addr_src_id,
      input  if_valid, id_valid, exe_valid, mem_valid, wb_valid,
      input  regw_addr_exe, regw_addr_mem, regw_addr_wb,
      input  wb_wen_exe, wb_wen_mem, wb_wen_wb,
      input  wb_data_src_exe, wb_data_src_mem, wb_data_src_wb,
      input  is_branch_exe, is_branch_mem, mem_ren_mem, mem_wen_mem,
      input  retired_cnt, bubble_cnt, flush_cnt
   );

   modport slave (
      input  if_rst, id_rst, exe_rst, mem_rst, wb_rst,
      input  if_en, id_en, exe_en, mem_en, wb_en,
      input  inst_id, is_branch_id, mem_ren_id, mem_wen_id, wb_wen_id, wb_data_src_id, wb_addr_src_id,
      output if_valid, id_valid, exe_valid, mem_valid, wb_valid,
      output regw_addr_exe, regw_addr_mem, regw_addr_wb,
      output wb_wen_exe, wb_wen_mem, wb_wen_wb,
      output wb_data_src_exe, wb_data_src_mem, wb_data_src_wb,
      output is_branch_exe, is_branch_mem, mem_ren_mem, mem_wen_mem,
      output retired_cnt, bubble_cnt, flush_cnt
   );
endinterface

// File: rtl/pipe_ctrl_regs.sv
// Control-side pipeline registers of the 5-stage MIPS core: carries ID decode
// through EXE/MEM/WB, returns stage valids and hazard feedback, and keeps
// saturating retired/bubble/flush counters.
// Ports: clk, rst (sync, active-high), bus (pipe_ctrl_regs_if.slave).
module pipe_ctrl_regs #(
   parameter int unsigned CNT_W = 32
) (
   input logic             clk,
   input logic             rst,
   pipe_ctrl_regs_if.slave bus
);
   localparam int unsigned ADDR_W   = 5;
   localparam int unsigned LINK_REG = 31;

   // Enable/strobe bits are stored already ANDed with the stage valid, so
   // every gated output is a plain flop.
   typedef struct packed {
      logic              valid;
      logic [ADDR_W-1:0] regw_addr;
      logic              wb_wen;
      logic              wb_data_src;
      logic              is_branch;
      logic              mem_ren;
      logic              mem_wen;
   } exe_mem_t;

   typedef struct packed {
      logic              valid;
      logic [ADDR_W-1:0] regw_addr;
      logic              wb_wen;
      logic              wb_data_src;
   } wb_t;

   logic              if_valid_q, id_valid_q;
   exe_mem_t          exe_q, mem_q, exe_d;
   wb_t               wb_q, wb_d;
   logic [ADDR_W-1:0] regw_addr_id;
   logic [CNT_W-1:0]  retired_q, bubble_q, flush_q;
   logic              unused_inst;

   assign unused_inst = ^{bus.inst_id[31:21], bus.inst_id[10:0]};

   // destination register select
   always_comb begin
      regw_addr_id = '0;
      case (bus.wb_addr_src_id)
         2'd0:    regw_addr_id = bus.inst_id[15:11];
         2'd1:    regw_addr_id = bus.inst_id[20:16];
         2'd2:    regw_addr_id = ADDR_W'(LINK_REG);
         default: regw_addr_id = '0;
      endcase
   end

   // EXE load value from ID decode
   always_comb begin
      exe_d             = '0;
      exe_d.valid       = id_valid_q;
      exe_d.regw_addr   = regw_addr_id;
      exe_d.wb_wen      = bus.wb_wen_id & id_valid_q;
      exe_d.wb_data_src = bus.wb_data_src_id;
      exe_d.is_branch   = bus.is_branch_id & id_valid_q;
      exe_d.mem_ren     = bus.mem_ren_id & id_valid_q;
      exe_d.mem_wen     = bus.mem_wen_id & id_valid_q;
   end

   // WB load value from MEM
   always_comb begin
      wb_d             = '0;
      wb_d.valid       = mem_q.valid;
      wb_d.regw_addr   = mem_q.regw_addr;
      wb_d.wb_wen      = mem_q.wb_wen;
      wb_d.wb_data_src = mem_q.wb_data_src;
   end

   // stage registers: clear, then load, then hold
   always_ff @(posedge clk) begin
      if (rst) begin
         if_valid_q <= 1'b0;
         id_valid_q <= 1'b0;
         exe_q      <= '0;
         mem_q      <= '0;
         wb_q       <= '0;
      end else begin
         if (bus.if_rst)      if_valid_q <= 1'b0;
         else if (bus.if_en)  if_valid_q <= 1'b1;

         if (bus.id_rst)      id_valid_q <= 1'b0;
         else if (bus.id_en)  id_valid_q <= if_valid_q;

         if (bus.exe_rst)     exe_q <= '0;
         else if (bus.exe_en) exe_q <= exe_d;

         if (bus.mem_rst)     mem_q <= '0;
         else if (bus.mem_en) mem_q <= exe_q;

         if (bus.wb_rst)      wb_q <= '0;
         else if (bus.wb_en)  wb_q <= wb_d;
      end
   end

   // saturating performance counters
   always_ff @(posedge clk) begin
      if (rst) begin
         retired_q <= '0;
         bubble_q  <= '0;
         flush_q   <= '0;
      end else begin
         if (bus.wb_en && !bus.wb_rst && mem_q.valid && (retired_q != '1))
            retired_q <= retired_q + CNT_W'(1);
         if (bus.exe_rst && (bubble_q != '1))
            bubble_q <= bubble_q + CNT_W'(1);
         if (bus.id_rst && (flush_q != '1))
            flush_q <= flush_q + CNT_W'(1);
      end
   end

   assign bus.if_valid        = if_valid_q;
   assign bus.id_valid        = id_valid_q;
   assign bus.exe_valid       = exe_q.valid;
   assign bus.mem_valid       = mem_q.valid;
   assign bus.wb_valid        = wb_q.valid;
   assign bus.regw_addr_exe   = exe_q.regw_addr;
   assign bus.regw_addr_mem   = mem_q.regw_addr;
   assign bus.regw_addr_wb    = wb_q.regw_addr;
   assign bus.wb_wen_exe      = exe_q.wb_wen;
   assign bus.wb_wen_mem      = mem_q.wb_wen;
   assign bus.wb_wen_wb       = wb_q.wb_wen;
   assign bus.wb_data_src_exe = exe_q.wb_data_src;
   assign bus.wb_data_src_mem = mem_q.wb_data_src;
   assign bus.wb_data_src_wb  = wb_q.wb_data_src;
   assign bus.is_branch_exe   = exe_q.is_branch;
   assign bus.is_branch_mem   = mem_q.is_branch;
   assign bus.mem_ren_mem     = mem_q.mem_ren;
   assign bus.mem_wen_mem     = mem_q.mem_wen;
   assign bus.retired_cnt     = retired_q;
   assign bus.bubble_cnt      = bubble_q;
   assign bus.flush_cnt       = flush_q;
endmodule
